led_blinker: RTL and testbench



---
 rtl/led_blinker.sv | 56 +++++
 tb/tb_led_blinker.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/led_blinker.sv
`timescale 1ns/1ps
// Heartbeat LED driver: a free-running cycle counter toggles one LED every CNT_MAX+1 clocks.
// The differential system clock is merged to one internal clock; reset is asynchronous and active-high.
module led_blinker #(
    parameter int   CNT_MAX    = 199_999_999,
    parameter int   CNT_W      = 28,
    parameter logic LED_RST    = 1'b0,
    parameter logic LED_ACTIVE = 1'b1
) (
    input  logic sys_clk_p,
    input  logic sys_clk_n,
    input  logic rst_n,
    output logic led
);

    generate
        if ((64'd1 << CNT_W) <= 64'(CNT_MAX)) begin : g_cnt_w_too_small
            $error("led_blinker: CNT_W too narrow to hold CNT_MAX");
        end
    endgenerate

    localparam logic [CNT_W-1:0] TERM = CNT_W'(CNT_MAX);

    // Behavioural stand-in for the differential input buffer: follows the
    // positive leg whenever the two legs are complementary.
    logic clk;
    assign clk = sys_clk_p & ~sys_clk_n;

    logic [CNT_W-1:0] cnt_p0;
    logic             state_p0;
    logic             state_nx;

    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c);
        return (c == TERM) ? '0 : c + CNT_W'(1);
    endfunction

    function automatic logic led_level(input logic s);
        return LED_ACTIVE ? s : ~s;
    endfunction

    assign state_nx = state_p0 ^ (cnt_p0 == TERM);

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_p0   <= '0;
            state_p0 <= 1'b0;
            led      <= LED_RST;
        end else begin
            cnt_p0   <= next_cnt(cnt_p0);
            state_p0 <= state_nx;
            led      <= led_level(state_nx);
        end
    end

endmodule

// File: tb/tb_led_blinker.sv
`timescale 1ns/1ps
// Self-checking bench for led_blinker: three builds (normal, CNT_MAX=0, inverted LED)
// driven from one clock and reset, compared against an edge-count reference model.
module tb_led_blinker;

    logic sys_clk_p = 1'b0;
    logic sys_clk_n;
    logic rst_n;
    logic led_a, led_z, led_i;

    assign sys_clk_n = ~sys_clk_p;
    always #2.5 sys_clk_p = ~sys_clk_p;

    led_blinker #(.CNT_MAX(9), .CNT_W(4), .LED_RST(1'b0), .LED_ACTIVE(1'b1)) dut_a (
        .sys_clk_p(sys_clk_p), .sys_clk_n(sys_clk_n), .rst_n(rst_n), .led(led_a));
    led_blinker #(.CNT_MAX(0), .CNT_W(1), .LED_RST(1'b0), .LED_ACTIVE(1'b1)) dut_z (
        .sys_clk_p(sys_clk_p), .sys_clk_n(sys_clk_n), .rst_n(rst_n), .led(led_z));
    led_blinker #(.CNT_MAX(9), .CNT_W(4), .LED_RST(1'b1), .LED_ACTIVE(1'b0)) dut_i (
        .sys_clk_p(sys_clk_p), .sys_clk_n(sys_clk_n), .rst_n(rst_n), .led(led_i));

    int n_checks = 0;
    int n_fail   = 0;
    int e        = 0;   // rising edges seen since the last reset release
    bit in_rst   = 1'b1;

    // Reference: the LED state is the parity of completed toggle periods.
    function automatic logic model(int edges, int period, logic act, logic rstv, bit r);
        logic s;
        if (r) return rstv;
        s = ((edges / period) % 2) != 0;
        return act ? s : ~s;
    endfunction

    task automatic check(string tag, logic obs, logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b (edges=%0d)", tag, obs, exp, e);
        end
    endtask

    task automatic check_vec(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, "_a"}, led_a, model(e, 10, 1'b1, 1'b0, in_rst));
        check({tag, "_z"}, led_z, model(e, 1,  1'b1, 1'b0, in_rst));
        check({tag, "_i"}, led_i, model(e, 10, 1'b0, 1'b1, in_rst));
    endtask

    task automatic tick();
        @(posedge sys_clk_p);
        if (!in_rst) e++;
        #1;
    endtask

    initial begin
        int  tr_a, tr_z;
        logic prev_a, prev_z;
        real d;

        // Phase 1: held in reset for 1000 ns
        rst_n  = 1'b1;
        in_rst = 1'b1;
        #0.5;
        check_all("rst_initial");
        repeat (200) begin
            tick();
            check_all("rst_hold");
        end
        check_vec("rst_cnt", 32'(dut_a.cnt_p0), 32'd0);

        // Phase 2: release and run two full blink periods
        rst_n  = 1'b0;
        in_rst = 1'b0;
        e      = 0;
        repeat (40) begin
            tick();
            check_all("run");
        end

        // Phase 3: asynchronous reset with led high and cnt=5
        repeat (15) begin
            tick();
            check_all("run_pre");
        end
        check_vec("mid_cnt", 32'(dut_a.cnt_p0), 32'd5);
        check("mid_led_high", led_a, 1'b1);
        rst_n  = 1'b1;
        in_rst = 1'b1;
        e      = 0;
        #0.2;
        check_all("async_rst");
        check_vec("async_cnt", 32'(dut_a.cnt_p0), 32'd0);
        repeat (3) begin
            tick();
            check_all("async_hold");
        end
        rst_n  = 1'b0;
        in_rst = 1'b0;
        repeat (25) begin
            tick();
            check_all("after_rst");
        end

        // Phase 4: random runs with random asynchronous reset pulses
        repeat (600) begin
            if ($urandom_range(0, 19) == 0) begin
                d = $urandom_range(1, 25) * 0.1;
                #(d);
                rst_n  = 1'b1;
                in_rst = 1'b1;
                e      = 0;
                #0.2;
                check_all("rnd_async");
                repeat ($urandom_range(0, 3)) begin
                    tick();
                    check_all("rnd_hold");
                end
                tick();
                rst_n  = 1'b0;
                in_rst = 1'b0;
            end else begin
                tick();
                check_all("rnd_run");
            end
        end

        // Phase 5: 1000 full periods from a clean release, counting transitions
        rst_n  = 1'b1;
        in_rst = 1'b1;
        e      = 0;
        tick();
        rst_n  = 1'b0;
        in_rst = 1'b0;
        tr_a   = 0;
        tr_z   = 0;
        prev_a = led_a;
        prev_z = led_z;
        repeat (20000) begin
            tick();
            check_all("long");
            if (led_a !== prev_a) tr_a++;
            if (led_z !== prev_z) tr_z++;
            prev_a = led_a;
            prev_z = led_z;
        end
        check_vec("long_trans_a", 32'(tr_a), 32'd2000);
        check_vec("long_trans_z", 32'(tr_z), 32'd20000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
